// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: steps a one-hot load enable across NUM_REGS byte slots
// on each verified-byte strobe. Optional idle watchdog: RX_FRAME_TIMEOUT_EN.
module rx_frame_sequencer #(
    parameter int NUM_REGS       = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    localparam int IDX_W         = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inicio_datos,
    input  logic                cod_verificado,
    input  logic                abort,
    output logic [NUM_REGS-1:0] registros,
    output logic                active,
    output logic                busy,
    output logic [IDX_W-1:0]    index,
    output logic                timeout_err,
    output logic [7:0]          frame_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DONE    = 2'b10
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [7:0]       frame_cnt_q;
    logic             to_hit;

`ifdef RX_FRAME_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_q, wd_d;
    logic        to_err_q;

    // Watchdog: counts silent CAPTURE cycles, cleared by strobes and outside CAPTURE
    always_comb begin
        to_hit = 1'b0;
        wd_d   = '0;
        if (state_q == CAPTURE && !cod_verificado) begin
            wd_d = wd_q + 16'd1;
            if (wd_q == TO_LAST) begin
                to_hit = !abort;
                wd_d   = '0;
            end
        end
    end

    // Watchdog counter and one-cycle error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q     <= '0;
            to_err_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            to_err_q <= to_hit;
        end
    end

    assign timeout_err = to_err_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State and slot index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Next-state logic: abort beats strobe, strobe beats timeout
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                index_d = '0;
                if (inicio_datos) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                    index_d = '0;
                end else if (cod_verificado) begin
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end else if (to_hit) begin
                    state_d = IDLE;
                    index_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                index_d = '0;
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    // Completed-frame counter, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (state_q == DONE) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        registros = '0;
        busy      = 1'b0;
        active    = 1'b0;
        index     = '0;
        case (state_q)
            CAPTURE: begin
                registros[index_q] = 1'b1;
                busy               = 1'b1;
                index              = index_q;
            end
            DONE: begin
                active = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Bench for rx_frame_sequencer: vector table, random run against a
// behavioural model, and hand-written corner sequences.
module tb_rx_frame_sequencer;

    localparam int TO8 = 10;
    localparam int TO4 = 50000;
`ifdef RX_FRAME_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, ini4, stb4, ab4;
    logic [3:0] reg4;
    logic       act4, busy4, te4;
    logic [1:0] idx4;
    logic [7:0] fc4;

    logic       rst8, ini8, stb8, ab8;
    logic [7:0] reg8;
    logic       act8, busy8, te8;
    logic [2:0] idx8;
    logic [7:0] fc8;

    rx_frame_sequencer #(.NUM_REGS(4)) dut4 (
        .clk(clk), .rst(rst4), .inicio_datos(ini4),
        .cod_verificado(stb4), .abort(ab4), .registros(reg4),
        .active(act4), .busy(busy4), .index(idx4),
        .timeout_err(te4), .frame_cnt(fc4)
    );

    rx_frame_sequencer #(.NUM_REGS(8), .TIMEOUT_CYCLES(TO8)) dut8 (
        .clk(clk), .rst(rst8), .inicio_datos(ini8),
        .cod_verificado(stb8), .abort(ab8), .registros(reg8),
        .active(act8), .busy(busy8), .index(idx8),
        .timeout_err(te8), .frame_cnt(fc8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model of the 4-slot instance
    bit m_cap, m_done, m_to;
    int m_slot, m_frames, m_quiet;

    task automatic model_reset();
        m_cap = 0; m_done = 0; m_to = 0;
        m_slot = 0; m_frames = 0; m_quiet = 0;
    endtask

    task automatic model_step(input bit ini, input bit stb, input bit ab);
        bit nc, nd, nt;
        int ns, nq;
        nc = m_cap; nd = 0; nt = 0; ns = m_slot; nq = m_quiet;
        if (m_done) begin
            m_frames = (m_frames + 1) % 256;
            nc = 0; ns = 0;
        end else if (!m_cap) begin
            if (ini) begin nc = 1; ns = 0; nq = 0; end
        end else if (ab) begin
            nc = 0; ns = 0;
        end else if (stb) begin
            nq = 0;
            if (m_slot == 3) begin nc = 0; nd = 1; ns = 0; end
            else ns = m_slot + 1;
        end else begin
            nq = m_quiet + 1;
            if (TO_EN && nq >= TO4) begin nc = 0; ns = 0; nt = 1; end
        end
        m_cap = nc; m_done = nd; m_to = nt; m_slot = ns; m_quiet = nq;
    endtask

    task automatic chk4_model();
        chk("m_reg", reg4, m_cap ? (32'd1 << m_slot) : 32'd0);
        chk("m_act", act4, m_done);
        chk("m_busy", busy4, m_cap);
        chk("m_idx", idx4, m_cap ? m_slot : 0);
        chk("m_to", te4, m_to);
        chk("m_fc", fc4, m_frames);
    endtask

    // One clock on the 4-slot instance, checked against the model
    task automatic cyc4(input bit ini, input bit stb, input bit ab);
        chk4_model();
        ini4 = ini; stb4 = stb; ab4 = ab;
        @(posedge clk);
        model_step(ini, stb, ab);
        @(negedge clk);
    endtask

    task automatic tick8(input bit ini, input bit stb, input bit ab);
        ini8 = ini; stb8 = stb; ab8 = ab;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit         ini, stb, ab;
        logic [3:0] e_reg;
        logic       e_act, e_busy;
        logic [1:0] e_idx;
        logic [7:0] e_fc;
    } vec_t;

    vec_t vt[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1);
    end

    initial begin
        rst4 = 1; ini4 = 0; stb4 = 0; ab4 = 0;
        rst8 = 1; ini8 = 0; stb8 = 0; ab8 = 0;
        model_reset();

        vt[0]  = '{1, 0, 0, 4'b0000, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 4'b0001, 0, 1, 0, 0};
        vt[2]  = '{1, 0, 0, 4'b0001, 0, 1, 0, 0};
        vt[3]  = '{0, 1, 0, 4'b0001, 0, 1, 0, 0};
        vt[4]  = '{0, 0, 0, 4'b0010, 0, 1, 1, 0};
        vt[5]  = '{0, 0, 0, 4'b0010, 0, 1, 1, 0};
        vt[6]  = '{0, 1, 0, 4'b0010, 0, 1, 1, 0};
        vt[7]  = '{0, 0, 0, 4'b0100, 0, 1, 2, 0};
        vt[8]  = '{0, 0, 0, 4'b0100, 0, 1, 2, 0};
        vt[9]  = '{0, 1, 0, 4'b0100, 0, 1, 2, 0};
        vt[10] = '{0, 0, 0, 4'b1000, 0, 1, 3, 0};
        vt[11] = '{0, 0, 0, 4'b1000, 0, 1, 3, 0};
        vt[12] = '{0, 1, 0, 4'b1000, 0, 1, 3, 0};
        vt[13] = '{1, 0, 1, 4'b0000, 1, 0, 0, 0};
        vt[14] = '{0, 1, 0, 4'b0000, 0, 0, 0, 1};
        vt[15] = '{0, 0, 0, 4'b0000, 0, 0, 0, 1};

        #1;
        chk("rst_reg4", reg4, 0);
        chk("rst_act4", act4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_fc4", fc4, 0);
        chk("rst_reg8", reg8, 0);
        chk("rst_te8", te8, 0);
        @(negedge clk);
        @(negedge clk);
        rst4 = 0; rst8 = 0;

        // Spaced-strobe frame from the vector table
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("v%0d_reg", i), reg4, vt[i].e_reg);
            chk($sformatf("v%0d_act", i), act4, vt[i].e_act);
            chk($sformatf("v%0d_busy", i), busy4, vt[i].e_busy);
            chk($sformatf("v%0d_idx", i), idx4, vt[i].e_idx);
            chk($sformatf("v%0d_fc", i), fc4, vt[i].e_fc);
            cyc4(vt[i].ini, vt[i].stb, vt[i].ab);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc4($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset at index 2
        cyc4(0, 0, 1);
        cyc4(0, 0, 1);
        cyc4(1, 0, 0);
        cyc4(0, 1, 0);
        cyc4(0, 1, 0);
        ini4 = 0; stb4 = 0; ab4 = 0;
        @(posedge clk);
        #1;
        chk("pre_rst_idx", idx4, 2);
        #1;
        rst4 = 1;
        #1;
        chk("arst_reg", reg4, 0);
        chk("arst_idx", idx4, 0);
        chk("arst_busy", busy4, 0);
        chk("arst_act", act4, 0);
        chk("arst_fc", fc4, 0);
        @(negedge clk);
        rst4 = 0;
        model_reset();
        cyc4(0, 1, 0);
        cyc4(0, 1, 0);
        cyc4(1, 0, 0);
        repeat (4) cyc4(0, 1, 0);
        chk("post_rst_act", act4, 1);
        cyc4(0, 0, 0);
        chk("post_rst_fc", fc4, 1);

        // 256 frames wrap the counter
        rst4 = 1;
        @(negedge clk);
        rst4 = 0;
        model_reset();
        for (int f = 0; f < 256; f++) begin
            if (f == 255) chk("fc_255", fc4, 255);
            cyc4(1, 0, 0);
            repeat (4) cyc4(0, 1, 0);
            cyc4(0, 0, 0);
        end
        chk("fc_wrap", fc4, 0);
        cyc4(0, 0, 0);

        // Eight back-to-back strobes on the 8-slot instance
        tick8(1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b2b_idx%0d", k), idx8, k);
            chk($sformatf("b2b_reg%0d", k), reg8, 32'd1 << k);
            chk($sformatf("b2b_busy%0d", k), busy8, 1);
            chk($sformatf("b2b_act%0d", k), act8, 0);
            tick8(0, 1, 0);
        end
        chk("b2b_done_act", act8, 1);
        chk("b2b_done_reg", reg8, 0);
        chk("b2b_done_busy", busy8, 0);
        tick8(0, 1, 0);
        chk("b2b_after_act", act8, 0);
        chk("b2b_fc", fc8, 1);
        for (int k = 0; k < 8; k++) begin
            tick8(0, 1, 0);
            chk($sformatf("idle_stb_reg%0d", k), reg8, 0);
            chk($sformatf("idle_stb_busy%0d", k), busy8, 0);
            chk($sformatf("idle_stb_idx%0d", k), idx8, 0);
        end

        // Abort together with the second strobe
        tick8(1, 0, 0);
        tick8(0, 1, 0);
        chk("ab_pre_idx", idx8, 1);
        tick8(0, 1, 1);
        chk("ab_busy", busy8, 0);
        chk("ab_reg", reg8, 0);
        chk("ab_idx", idx8, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("ab_act%0d", k), act8, 0);
            tick8(0, 0, 0);
        end
        chk("ab_fc", fc8, 1);

`ifdef RX_FRAME_TIMEOUT_EN
        // Silence after one strobe trips the watchdog
        tick8(1, 0, 0);
        tick8(0, 1, 0);
        for (int n = 0; n < 12; n++) begin
            chk($sformatf("to_err%0d", n), te8, n == TO8);
            chk($sformatf("to_busy%0d", n), busy8, n < TO8);
            chk($sformatf("to_act%0d", n), act8, 0);
            tick8(0, 0, 0);
        end
        chk("to_idx", idx8, 0);
        chk("to_fc", fc8, 1);
`else
        // Without the watchdog CAPTURE waits forever
        tick8(1, 0, 0);
        tick8(0, 1, 0);
        repeat (1000) tick8(0, 0, 0);
        chk("nto_busy", busy8, 1);
        chk("nto_err", te8, 0);
        chk("nto_idx", idx8, 1);
        tick8(0, 0, 1);
        chk("nto_abort", busy8, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
